nf_rule_verdict: RTL and testbench

Downstream consumer of the non-fast-pattern stage. It pairs each per-packet metadata flit with that packet's rule-match list, which arrives as a multi-flit rule stream. It counts the non-zero rule IDs and writes the saturated count and a hit flag into the metadata before passing it on to the packet-steering logic. The block also keeps 32-bit statistics for the CSR block.

---
 rtl/nf_verdict_pkg.sv | 15 +
 rtl/avl_stream_if.sv | 15 +
 rtl/rule_slot_popcount.sv | 34 +++
 rtl/stats_cnt.sv | 18 +
 rtl/nf_rule_verdict.sv | 114 +++++++++++
 tb/tb_nf_rule_verdict.sv | 221 ++++++++++++++++++++++
 6 files changed

// File: rtl/nf_verdict_pkg.sv
// Shared types and constants for the rule-verdict stage.
package nf_verdict_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int          SLOT_W    = 16;
    localparam int          HIT_BIT   = 16;
    localparam int          ACC_W     = 17;
    localparam logic [15:0] COUNT_SAT = 16'hFFFF;

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style stream bundle with packet framing and byte-empty field.
interface avl_stream_if #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;

    modport tx (output valid, data, sop, eop, empty, input ready);
    modport rx (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/rule_slot_popcount.sv
// Counts non-zero 16-bit rule slots in a flit; on eop only the slots covered
// by non-empty bytes take part.
module rule_slot_popcount
    import nf_verdict_pkg::*;
#(
    parameter int RULE_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int CNT_W   = $clog2(RULE_W/SLOT_W + 1)
) (
    input  logic [RULE_W-1:0]  flit,
    input  logic               eop,
    input  logic [EMPTY_W-1:0] empty,
    output logic [CNT_W-1:0]   cnt
);
    localparam int NSLOT   = RULE_W / SLOT_W;
    localparam int BYTES   = RULE_W / 8;
    localparam int BYTES_W = $clog2(BYTES + 1);

    logic [BYTES_W-1:0] bytes_valid;
    logic [BYTES_W-1:0] slots_valid;

    assign bytes_valid = BYTES_W'(BYTES) - BYTES_W'(empty);
    assign slots_valid = bytes_valid >> 1;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if ((flit[k*SLOT_W +: SLOT_W] != '0) &&
                (!eop || (BYTES_W'(k) < slots_valid))) begin
                cnt = cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/stats_cnt.sv
// Wrapping statistics accumulator.
module stats_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    input  logic [W-1:0] inc_val,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc_en) begin
            cnt <= cnt + inc_val;
        end
    end
endmodule

// File: rtl/nf_rule_verdict.sv
// Pairs each metadata flit with its rule list, stamps {hit, saturated count}
// into the low meta bits and keeps per-packet statistics.
//
// state | meaning
// IDLE  | waiting for a metadata flit
// COUNT | accumulating rule slots until the eop rule flit
// EMIT  | presenting annotated metadata until accepted
module nf_rule_verdict
    import nf_verdict_pkg::*;
#(
    parameter int META_W  = 512,
    parameter int RULE_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    avl_stream_if.rx    in_meta,
    avl_stream_if.rx    in_usr,
    avl_stream_if.tx    out_meta,
    output logic [31:0] stats_pkt,
    output logic [31:0] stats_hit,
    output logic [31:0] stats_rules,
    output logic [31:0] stats_err
);
    localparam int CNT_W = $clog2(RULE_W/SLOT_W + 1);

    state_t                    state_q, state_d;
    logic [META_W-1:HIT_BIT+1] meta_q;
    logic [ACC_W-1:0]          acc_q;
    logic                      first_q;
    logic [CNT_W-1:0]          rule_cnt;
    logic [15:0]               count;
    logic                      hit;
    logic                      meta_take, rule_take, emit_done, sop_err;

    rule_slot_popcount #(
        .RULE_W  (RULE_W),
        .EMPTY_W (EMPTY_W),
        .CNT_W   (CNT_W)
    ) u_popcount (
        .flit  (in_usr.data),
        .eop   (in_usr.eop),
        .empty (in_usr.empty),
        .cnt   (rule_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        in_meta.ready  = 1'b0;
        in_usr.ready   = 1'b0;
        out_meta.valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_meta.ready = 1'b1;
                if (in_meta.valid) state_d = COUNT;
            end
            COUNT: begin
                in_usr.ready = 1'b1;
                if (in_usr.valid && in_usr.eop) state_d = EMIT;
            end
            EMIT: begin
                out_meta.valid = 1'b1;
                if (out_meta.ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign meta_take = in_meta.ready && in_meta.valid;
    assign rule_take = in_usr.ready && in_usr.valid;
    assign emit_done = out_meta.valid && out_meta.ready;
    assign sop_err   = rule_take && first_q && !in_usr.sop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= '0;
            acc_q   <= '0;
            first_q <= 1'b0;
        end else if (meta_take) begin
            meta_q  <= in_meta.data[META_W-1:HIT_BIT+1];
            acc_q   <= '0;
            first_q <= 1'b1;
        end else if (rule_take) begin
            acc_q   <= acc_q + ACC_W'(rule_cnt);
            first_q <= 1'b0;
        end
    end

    assign count = (acc_q > {1'b0, COUNT_SAT}) ? COUNT_SAT : acc_q[15:0];
    assign hit   = (acc_q != '0);

    assign out_meta.data  = {meta_q, hit, count};
    assign out_meta.sop   = 1'b1;
    assign out_meta.eop   = 1'b1;
    assign out_meta.empty = '0;

    stats_cnt #(.W(32)) u_stats_pkt (
        .clk(clk), .rst_n(rst_n), .inc_en(emit_done), .inc_val(32'd1), .cnt(stats_pkt));
    stats_cnt #(.W(32)) u_stats_hit (
        .clk(clk), .rst_n(rst_n), .inc_en(emit_done && hit), .inc_val(32'd1), .cnt(stats_hit));
    stats_cnt #(.W(32)) u_stats_rules (
        .clk(clk), .rst_n(rst_n), .inc_en(emit_done), .inc_val(32'(acc_q)), .cnt(stats_rules));
    stats_cnt #(.W(32)) u_stats_err (
        .clk(clk), .rst_n(rst_n), .inc_en(sop_err), .inc_val(32'd1), .cnt(stats_err));

endmodule

// File: tb/tb_nf_rule_verdict.sv
// Directed bench for nf_rule_verdict: vector table plus backpressure and reset sequences.
module tb_nf_rule_verdict;
    localparam int META_W  = 512;
    localparam int RULE_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int BOUND   = 200;

    typedef struct {
        logic [META_W-1:0]  meta;
        int                 nflits;
        logic [RULE_W-1:0]  flit;
        logic               first_sop;
        logic [EMPTY_W-1:0] last_empty;
        logic [15:0]        exp_count;
        logic               exp_hit;
        logic [31:0]        exp_rules;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] stats_pkt, stats_hit, stats_rules, stats_err;

    avl_stream_if #(.DATA_W(META_W), .EMPTY_W(EMPTY_W)) in_meta_if ();
    avl_stream_if #(.DATA_W(RULE_W), .EMPTY_W(EMPTY_W)) in_usr_if ();
    avl_stream_if #(.DATA_W(META_W), .EMPTY_W(EMPTY_W)) out_meta_if ();

    nf_rule_verdict #(.META_W(META_W), .RULE_W(RULE_W), .EMPTY_W(EMPTY_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_meta     (in_meta_if),
        .in_usr      (in_usr_if),
        .out_meta    (out_meta_if),
        .stats_pkt   (stats_pkt),
        .stats_hit   (stats_hit),
        .stats_rules (stats_rules),
        .stats_err   (stats_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pkt, m_hit, m_rules, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [META_W-1:0] mk_meta(input int i);
        return {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic send_meta(input logic [META_W-1:0] d);
        int n = 0;
        in_meta_if.valid = 1'b1;
        in_meta_if.data  = d;
        while (!in_meta_if.ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_meta_if.ready) begin
            errors++;
            $display("FAIL meta_accept_timeout: got not-ready expected ready");
        end
        @(posedge clk);
        @(negedge clk);
        in_meta_if.valid = 1'b0;
    endtask

    task automatic send_rule(input logic [RULE_W-1:0] d, input logic s, input logic e,
                             input logic [EMPTY_W-1:0] em);
        int n = 0;
        in_usr_if.valid = 1'b1;
        in_usr_if.data  = d;
        in_usr_if.sop   = s;
        in_usr_if.eop   = e;
        in_usr_if.empty = em;
        while (!in_usr_if.ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_usr_if.ready) begin
            errors++;
            $display("FAIL rule_accept_timeout: got not-ready expected ready");
        end
        @(posedge clk);
        @(negedge clk);
        in_usr_if.valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [15:0] ec, input logic eh,
                           input logic [META_W-1:0] em);
        int n = 0;
        while (!out_meta_if.valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_meta_if.valid), 64'd1);
        chk({tag, "_count"}, 64'(out_meta_if.data[15:0]), 64'(ec));
        chk({tag, "_hit"}, 64'(out_meta_if.data[16]), 64'(eh));
        chk({tag, "_upper"}, 64'(out_meta_if.data[META_W-1:17] == em[META_W-1:17]), 64'd1);
        chk({tag, "_frame"}, 64'({out_meta_if.sop, out_meta_if.eop, out_meta_if.empty}),
            64'({1'b1, 1'b1, 6'd0}));
        out_meta_if.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_meta_if.ready = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_stats_pkt"}, 64'(stats_pkt), 64'(m_pkt));
        chk({tag, "_stats_hit"}, 64'(stats_hit), 64'(m_hit));
        chk({tag, "_stats_rules"}, 64'(stats_rules), 64'(m_rules));
        chk({tag, "_stats_err"}, 64'(stats_err), 64'(m_err));
    endtask

    vec_t vecs[7];
    logic [RULE_W-1:0] pat3, full, s31, zero;
    logic [META_W-1:0] snap;

    initial begin
        in_meta_if.valid = 0; in_meta_if.data = '0; in_meta_if.sop = 1;
        in_meta_if.eop = 1; in_meta_if.empty = '0;
        in_usr_if.valid = 0; in_usr_if.data = '0; in_usr_if.sop = 0;
        in_usr_if.eop = 0; in_usr_if.empty = '0;
        out_meta_if.ready = 0;
        m_pkt = 0; m_hit = 0; m_rules = 0; m_err = 0;

        zero = '0;
        pat3 = '0;
        pat3[15:0] = 16'h0001; pat3[63:48] = 16'hBEEF; pat3[511:496] = 16'h8000;
        full = {32{16'h0101}};
        s31 = '0;
        s31[511:496] = 16'h1234;

        //            meta        n     flit  sop   empty   count     hit  rules
        vecs[0] = '{mk_meta(0), 1,    pat3, 1'b1, 6'd0,  16'd3,    1'b1, 32'd3};
        vecs[1] = '{mk_meta(1), 3,    full, 1'b1, 6'd60, 16'd66,   1'b1, 32'd66};
        vecs[2] = '{mk_meta(2), 1,    zero, 1'b1, 6'd0,  16'd0,    1'b0, 32'd0};
        vecs[3] = '{mk_meta(3), 1,    s31,  1'b1, 6'd2,  16'd0,    1'b0, 32'd0};
        vecs[4] = '{mk_meta(4), 1,    full, 1'b1, 6'd62, 16'd1,    1'b1, 32'd1};
        vecs[5] = '{mk_meta(5), 2,    pat3, 1'b0, 6'd0,  16'd6,    1'b1, 32'd6};
        vecs[6] = '{mk_meta(6), 2049, full, 1'b1, 6'd0,  16'hFFFF, 1'b1, 32'd65568};

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_meta_if.valid), 64'd0);
        check_stats("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_meta_ready", 64'(in_meta_if.ready), 64'd1);
        chk("idle_usr_ready", 64'(in_usr_if.ready), 64'd0);

        for (int v = 0; v < 7; v++) begin
            send_meta(vecs[v].meta);
            for (int f = 0; f < vecs[v].nflits; f++) begin
                send_rule(vecs[v].flit, (f == 0) ? vecs[v].first_sop : 1'b0,
                          f == vecs[v].nflits - 1,
                          (f == vecs[v].nflits - 1) ? vecs[v].last_empty : 6'd0);
            end
            collect($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_hit, vecs[v].meta);
            m_pkt++;
            if (vecs[v].exp_hit) m_hit++;
            m_rules += vecs[v].exp_rules;
            if (!vecs[v].first_sop) m_err++;
            check_stats($sformatf("vec%0d", v));
        end

        // Hold off the consumer for 10 cycles while the next meta is offered.
        send_meta(mk_meta(10));
        send_rule(pat3, 1'b1, 1'b1, 6'd0);
        in_meta_if.valid = 1'b1;
        in_meta_if.data  = mk_meta(11);
        snap = out_meta_if.data;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(out_meta_if.valid), 64'd1);
            chk("bp_stable", 64'(out_meta_if.data == snap), 64'd1);
            chk("bp_meta_ready", 64'(in_meta_if.ready), 64'd0);
            @(negedge clk);
        end
        chk("bp_low17", 64'(snap[16:0]), 64'({1'b1, 16'd3}));
        out_meta_if.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_meta_if.ready = 1'b0;
        chk("bp_after_valid", 64'(out_meta_if.valid), 64'd0);
        chk("bp_after_idle", 64'(in_meta_if.ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_meta_if.valid = 1'b0;
        chk("bp_next_count", 64'(in_meta_if.ready), 64'd0);
        send_rule(full, 1'b1, 1'b1, 6'd0);
        collect("bp_next", 16'd32, 1'b1, mk_meta(11));
        m_pkt += 2; m_hit += 2; m_rules += 35;
        check_stats("bp");

        // Reset in the middle of a two-flit list.
        send_meta(mk_meta(20));
        send_rule(full, 1'b1, 1'b0, 6'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_meta_if.valid), 64'd0);
        m_pkt = 0; m_hit = 0; m_rules = 0; m_err = 0;
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", 64'(in_meta_if.ready), 64'd1);
        send_meta(mk_meta(21));
        send_rule(pat3, 1'b1, 1'b1, 6'd0);
        collect("post_rst", 16'd3, 1'b1, mk_meta(21));
        m_pkt = 1; m_hit = 1; m_rules = 3;
        check_stats("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
